// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: bubble encoding, PC step and fetch FSM states.
// Also consumed by the IF/ID and ID/EX pipeline registers for NOP_INSTR.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Sequential PC step, wrapping modulo 2^32.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry buffer holding one fetched instruction and its PC while IF/ID holds.
module fetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);
    import fetch_unit_pkg::*;

    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] pc_r;

    // Buffer entry: clear wins over load so a redirect always empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= 32'd0;
        end else if (clear) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= 32'd0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= instr_in;
            pc_r    <= pc_in;
        end else begin
            valid_r <= valid_r;
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    assign valid = valid_r;
    assign instr = instr_r;
    assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky misalign_err output and aligns redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);
    import fetch_unit_pkg::*;

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic [31:0]  stale_addr_r;
    logic [31:0]  stale_addr_nxt_s;
    logic [31:0]  target_s;
    logic         buf_load_s;
    logic         buf_clear_s;
    logic         buf_valid_s;
    logic [31:0]  buf_instr_s;
    logic [31:0]  buf_pc_s;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err_r;

    assign target_s = {redirect_pc[31:2], 2'b00};

    // Sticky flag for any redirect to a non-word-aligned target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_r <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err_r <= 1'b1;
        end else begin
            misalign_err_r <= misalign_err_r;
        end
    end

    assign misalign_err = misalign_err_r;
`else
    assign target_s = redirect_pc;
`endif

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load_s),
        .clear    (buf_clear_s),
        .instr_in (imem_rdata),
        .pc_in    (pc_r),
        .valid    (buf_valid_s),
        .instr    (buf_instr_s),
        .pc       (buf_pc_s)
    );

    // State, PC and the address of a request being drained after a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            stale_addr_r <= RESET_PC;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            stale_addr_r <= stale_addr_nxt_s;
        end
    end

    // Next-state logic; a redirect overrides both hold and ack.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        stale_addr_nxt_s = stale_addr_r;
        buf_load_s       = 1'b0;
        buf_clear_s      = 1'b0;
        if (redirect_valid) begin
            pc_nxt_s    = target_s;
            buf_clear_s = 1'b1;
            case (state_r)
                S_REQ: begin
                    if (imem_ack) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s      = S_DROP;
                        stale_addr_nxt_s = pc_r;
                    end
                end
                // An ack arriving alongside the redirect still retires the stale request.
                S_DROP: begin
                    if (imem_ack) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_DROP;
                    end
                end
                default: state_nxt_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_IDLE: state_nxt_s = S_REQ;
                S_REQ: begin
                    if (imem_ack && hold) begin
                        buf_load_s  = 1'b1;
                        state_nxt_s = S_HOLD;
                    end else if (imem_ack) begin
                        pc_nxt_s = pc_step(pc_r);
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        pc_nxt_s    = pc_step(pc_r);
                        buf_clear_s = 1'b1;
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_DROP;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Memory request and IF/ID presentation; bubbles carry NOP_INSTR and pc_out 0.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = pc_r;
        fetch_valid = 1'b0;
        instr_out   = NOP_INSTR;
        pc_out      = 32'd0;
        case (state_r)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack && !redirect_valid) begin
                    fetch_valid = 1'b1;
                    instr_out   = imem_rdata;
                    pc_out      = pc_step(pc_r);
                end else begin
                    fetch_valid = 1'b0;
                end
            end
            S_HOLD: begin
                if (buf_valid_s && !redirect_valid) begin
                    fetch_valid = 1'b1;
                    instr_out   = buf_instr_s;
                    pc_out      = pc_step(buf_pc_s);
                end else begin
                    fetch_valid = 1'b0;
                end
            end
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = stale_addr_r;
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign flush = redirect_valid;

endmodule
